// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: beam position, syncs, lookahead fetch position, strobes.
// Optional raster-line interrupt is built when VIDEO_TIMING_IRQ_EN is defined.
module video_timing_gen #(
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int CE_DIV    = 1,
  parameter int LOOKAHEAD = 1,
  parameter int CW        = 9
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic          pix_ce_o,
  output logic [CW-1:0] hpos_o,
  output logic [CW-1:0] vpos_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          display_on_o,
  output logic [CW-1:0] fetch_hpos_o,
  output logic [CW-1:0] fetch_vpos_o,
  output logic          fetch_valid_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic [7:0]    frame_count_o
`ifdef VIDEO_TIMING_IRQ_EN
  ,
  input  logic [CW-1:0] irq_line_i,
  input  logic          irq_clear_i,
  output logic          irq_o
`endif
);

  localparam int H_MAX    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_MAX    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_BOTTOM;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int MAX_HV   = (H_MAX > V_MAX) ? H_MAX : V_MAX;
  localparam int DW       = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CW-1:0] H_MAX_C    = CW'(H_MAX);
  localparam logic [CW-1:0] V_MAX_C    = CW'(V_MAX);
  localparam logic [CW-1:0] H_DISP_C   = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_DISP_C   = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
  localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
  localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
  localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);
  localparam logic [CW-1:0] LOOK_C     = CW'(LOOKAHEAD);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CE_DIV - 1);

  if ((1 << CW) <= MAX_HV) begin : g_cw_check
    $error("video_timing_gen: CW too narrow for raster size");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d, fh_q, fh_d, fv_q, fv_d;
  logic          hsync_q, vsync_q, disp_q, fvalid_q, ls_q, fs_q, pix_ce;
  logic [7:0]    fc_q;

  // One step in scan order; fetch and beam counters share the same wrap rules.
  function automatic logic [2*CW-1:0] scan_step(input logic [CW-1:0] h, input logic [CW-1:0] v);
    logic [CW-1:0] nh, nv;
    nh = h + 1'b1;
    nv = v;
    if (h == H_MAX_C) begin
      nh = '0;
      nv = (v == V_MAX_C) ? '0 : v + 1'b1;
    end
    return {nh, nv};
  endfunction

  always_comb begin
    pix_ce = !reset_i && (div_q == DIV_LAST);
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    {h_d, v_d}   = {h_q, v_q};
    {fh_d, fv_d} = {fh_q, fv_q};
    if (pix_ce) begin
      {h_d, v_d}   = scan_step(h_q, v_q);
      {fh_d, fv_d} = scan_step(fh_q, fv_q);
    end
  end

  // Decoded outputs are registered from next-state counters so they line up with hpos/vpos.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      fh_q     <= LOOK_C;
      fv_q     <= '0;
      fvalid_q <= (LOOKAHEAD < H_DISPLAY);
      disp_q   <= 1'b1;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      fc_q     <= '0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      fh_q     <= fh_d;
      fv_q     <= fv_d;
      fvalid_q <= (fh_d < H_DISP_C) && (fv_d < V_DISP_C);
      disp_q   <= (h_d < H_DISP_C) && (v_d < V_DISP_C);
      hsync_q  <= (h_d >= HS_START_C && h_d <= HS_END_C) ? HS_POL : ~HS_POL;
      vsync_q  <= (v_d >= VS_START_C && v_d <= VS_END_C) ? VS_POL : ~VS_POL;
      ls_q     <= pix_ce && (h_d == '0);
      fs_q     <= pix_ce && (h_d == '0) && (v_d == '0);
      if (pix_ce && (h_d == '0) && (v_d == '0)) fc_q <= fc_q + 8'd1;
    end
  end

`ifdef VIDEO_TIMING_IRQ_EN
  logic irq_q;
  // Set wins over clear so an acknowledge racing a new hit cannot lose it.
  always_ff @(posedge clk_i) begin
    if (reset_i) irq_q <= 1'b0;
    else if (pix_ce && (h_d == H_DISP_C) && (v_d == irq_line_i)) irq_q <= 1'b1;
    else if (irq_clear_i) irq_q <= 1'b0;
  end
  assign irq_o = irq_q;
`endif

  assign pix_ce_o      = pix_ce;
  assign hpos_o        = h_q;
  assign vpos_o        = v_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign display_on_o  = disp_q;
  assign fetch_hpos_o  = fh_q;
  assign fetch_vpos_o  = fv_q;
  assign fetch_valid_o = fvalid_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;
  assign frame_count_o = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default instance over a full frame, plus a
// CE_DIV=2 / HS_POL=0 instance over the first two lines.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          pix_ce, hsync, vsync, de, fvalid, ls, fs;
  logic [8:0]    hpos, vpos, fh, fv;
  logic [7:0]    fc;
  logic          pix_ce2, hsync2, vsync2, de2, fvalid2, ls2, fs2;
  logic [8:0]    hpos2, vpos2, fh2, fv2;
  logic [7:0]    fc2;
`ifdef VIDEO_TIMING_IRQ_EN
  logic [8:0] irq_line = 9'd10;
  logic       irq_clear = 1'b0;
  logic       irq, irq2;
`endif

  video_timing_gen dut (
    .clk_i(clk), .reset_i(reset), .pix_ce_o(pix_ce), .hpos_o(hpos), .vpos_o(vpos),
    .hsync_o(hsync), .vsync_o(vsync), .display_on_o(de), .fetch_hpos_o(fh),
    .fetch_vpos_o(fv), .fetch_valid_o(fvalid), .line_start_o(ls), .frame_start_o(fs),
    .frame_count_o(fc)
`ifdef VIDEO_TIMING_IRQ_EN
    , .irq_line_i(irq_line), .irq_clear_i(irq_clear), .irq_o(irq)
`endif
  );

  video_timing_gen #(.CE_DIV(2), .HS_POL(1'b0)) dut2 (
    .clk_i(clk), .reset_i(reset), .pix_ce_o(pix_ce2), .hpos_o(hpos2), .vpos_o(vpos2),
    .hsync_o(hsync2), .vsync_o(vsync2), .display_on_o(de2), .fetch_hpos_o(fh2),
    .fetch_vpos_o(fv2), .fetch_valid_o(fvalid2), .line_start_o(ls2), .frame_start_o(fs2),
    .frame_count_o(fc2)
`ifdef VIDEO_TIMING_IRQ_EN
    , .irq_line_i(9'd300), .irq_clear_i(1'b0), .irq_o(irq2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  int h = 0, v = 0;
  int e_fh, e_fv;
  int pos_err = 0, hs_err = 0, vs_err = 0, de_err = 0, fetch_err = 0, ls_err = 0, fs_err = 0;
  int ce_err = 0, irq_err = 0, d2_err = 0;
  int de_cnt = 0, fs_cnt = 0;

  task automatic model_step();
    if (h == 308) begin
      h = 0;
      v = (v == 261) ? 0 : v + 1;
    end else h = h + 1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hpos"}, hpos, 0);
    check({tag, "_vpos"}, vpos, 0);
    check({tag, "_fetch_h"}, fh, 1);
    check({tag, "_fetch_v"}, fv, 0);
    check({tag, "_fetch_valid"}, fvalid, 1);
    check({tag, "_display_on"}, de, 1);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_line_start"}, ls, 0);
    check({tag, "_frame_count"}, fc, 0);
`ifdef VIDEO_TIMING_IRQ_EN
    check({tag, "_irq"}, irq, 0);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    check("rst_pix_ce", pix_ce, 0);
    check("rst_pix_ce2", pix_ce2, 0);
    check("rst_hsync2", hsync2, 1);
    reset = 1'b0;

    for (int n = 1; n <= 80958; n++) begin
      @(negedge clk);
      model_step();
      e_fh = (h == 308) ? 0 : h + 1;
      e_fv = (h == 308) ? ((v == 261) ? 0 : v + 1) : v;
      if (hpos !== 9'(h) || vpos !== 9'(v)) pos_err++;
      if (hsync !== (h >= 263 && h <= 285)) hs_err++;
      if (vsync !== (v >= 254 && v <= 256)) vs_err++;
      if (de !== (h < 256 && v < 240)) de_err++;
      if (fh !== 9'(e_fh) || fv !== 9'(e_fv) || fvalid !== (e_fh < 256 && e_fv < 240)) fetch_err++;
      if (ls !== (h == 0)) ls_err++;
      if (fs !== (h == 0 && v == 0)) fs_err++;
      if (pix_ce !== 1'b1) ce_err++;
      if (de === 1'b1) de_cnt++;
      if (fs === 1'b1) fs_cnt++;
      if (n <= 620) begin
        if (pix_ce2 !== 1'(n % 2) || hpos2 !== 9'((n / 2) % 309) || vpos2 !== 9'((n / 2) / 309) ||
            hsync2 !== !(((n / 2) % 309) >= 263 && ((n / 2) % 309) <= 285) ||
            ls2 !== (n % 2 == 0 && (n / 2) % 309 == 0)) d2_err++;
      end
      if (n == 309) begin
        check("l1_hpos", hpos, 0);
        check("l1_vpos", vpos, 1);
        check("l1_line_start", ls, 1);
        check("l1_frame_start", fs, 0);
      end
      if (n == 618) check("d2_line_start", ls2, 1);
      if (n == 80957) check("fc_before", fc, 0);
      if (n == 80958) begin
        check("frame_start_end", fs, 1);
        check("fc_after", fc, 1);
      end
      if (h == 308 && v == 261) begin
        check("wrap_fetch_h", fh, 0);
        check("wrap_fetch_v", fv, 0);
        check("wrap_fetch_valid", fvalid, 1);
      end
      if (h == 255 && v == 10) begin
        check("edge_fetch_h", fh, 256);
        check("edge_fetch_valid", fvalid, 0);
      end
      if (h == 308 && v == 239) begin
        check("last_fetch_v", fv, 240);
        check("last_fetch_valid", fvalid, 0);
      end
`ifdef VIDEO_TIMING_IRQ_EN
      if (irq !== (h == 256 && v == 10)) irq_err++;
      if (h == 256 && v == 10) check("irq_set_with_clear", irq, 1);
      if (h == 257 && v == 10) check("irq_cleared", irq, 0);
      irq_clear = (h == 255 && v == 10) || (h == 256 && v == 10);
      if (h == 256 && v == 10) irq_line = 9'd300;
`endif
    end

    check("pos_errors", pos_err, 0);
    check("hsync_errors", hs_err, 0);
    check("vsync_errors", vs_err, 0);
    check("display_on_errors", de_err, 0);
    check("fetch_errors", fetch_err, 0);
    check("line_start_errors", ls_err, 0);
    check("frame_start_errors", fs_err, 0);
    check("pix_ce_errors", ce_err, 0);
    check("display_on_count", de_cnt, 61440);
    check("frame_start_count", fs_cnt, 1);
    check("div2_errors", d2_err, 0);
`ifdef VIDEO_TIMING_IRQ_EN
    check("irq_errors", irq_err, 0);
`endif

    pos_err = 0;
    for (int n = 0; n < 309 + 270; n++) begin
      @(negedge clk);
      model_step();
      if (hpos !== 9'(h) || vpos !== 9'(v)) pos_err++;
    end
    check("mid_pos_errors", pos_err, 0);
    check("mid_hpos", hpos, 270);
    check("mid_hsync", hsync, 1);
    check("mid_frame_count", fc, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midrst");
    @(negedge clk);
    check("post_rst_hpos", hpos, 1);
    check("post_rst_vpos", vpos, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
